// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between two requesters
//   (port 0 = integer pipe, port 1 = address/CSR unit). A granted request
//   has its operands registered onto alu_*. The ALU result is captured one
//   cycle later and returned on a valid/ready response channel together
//   with the issuing port index and that request's opaque tag.
//   Latency is accept@T -> rsp_valid@T+2. Back-to-back throughput is one
//   op every two cycles.
//
// Parameters
//   DATA_W  operand/result width (must match the ALU)
//   TAG_W   requester tag width
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid/ready             request handshake for port N (ready is combinational)
//   reqN_a/b/op/tag              operands, ALU control code, tag for port N
//   rsp_valid/ready              response handshake
//   rsp_result/id/tag            captured ALU result, issuing port, its tag
//   alu_a/alu_b/alu_control      registered ALU inputs
//   alu_result                   combinational ALU output
//
// Build option
//   ALU_ARB_PRIO_EN  defined: strict priority, port 0 wins every tie.
//                    undefined (default): round-robin on ties.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result
);

`ifdef ALU_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [2:0]          alu_ctrl_q, alu_ctrl_d;
  logic                pend_id_q, pend_id_d;
  logic [TAG_W-1:0]    pend_tag_q, pend_tag_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;

  logic grant;
  logic accept_win;
  logic take;

  // Tie-break: round-robin flips away from the last winner; priority mode
  // keeps tracking last_grant but always favours port 0.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = PRIO_EN ? 1'b0 : ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // A new op may be taken while idle, or in the same cycle the current
  // response is consumed. Reset blocks acceptance outright.
  assign accept_win = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
  assign take       = !rst && accept_win && (req0_valid || req1_valid);
  assign req0_ready = take && !grant;
  assign req1_ready = take && grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    pend_id_d    = pend_id_q;
    pend_tag_d   = pend_tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;

    unique case (state_q)
      S_IDLE: begin
        if (take) state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d      = S_RESP;
        rsp_valid_d  = 1'b1;
        rsp_result_d = alu_result;
        rsp_id_d     = pend_id_q;
        rsp_tag_d    = pend_tag_q;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = take ? S_EXEC : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      alu_a_d      = grant ? req1_a   : req0_a;
      alu_b_d      = grant ? req1_b   : req0_b;
      alu_ctrl_d   = grant ? req1_op  : req0_op;
      pend_tag_d   = grant ? req1_tag : req0_tag;
      pend_id_d    = grant;
      last_grant_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      pend_id_q    <= 1'b0;
      pend_tag_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      pend_id_q    <= pend_id_d;
      pend_tag_q   <= pend_tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctrl_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_tag     = rsp_tag_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Self-checking bench for alu_share_arbiter. A behavioural ALU stands in
//   for the shared ALU. Expected responses are queued when a request is
//   expected to be accepted and are popped when rsp_valid is observed.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic [3:0]  rsp_tag;
  logic [2:0]  alu_control;

  typedef struct packed {
    logic [31:0] res;
    logic        id;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result)
  );

  // Stand-in ALU: ADD SUB XOR OR AND SHR SHL, code 7 returns 0.
  always_comb begin
    case (alu_control)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a ^ alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a & alu_b;
      3'd5:    alu_result = alu_a >> alu_b[4:0];
      3'd6:    alu_result = alu_a << alu_b[4:0];
      default: alu_result = '0;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req0_tag = '0;
    req1_a = '0; req1_b = '0; req1_op = '0; req1_tag = '0;
    rsp_ready = 1'b1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    sb.delete();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'h11; req1_a = 32'h22;
    tick(); tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); else passes++;
    checks++; if (rsp_result !== 32'h0) $display("FAIL reset_rsp_result: got %h want 0", rsp_result); else passes++;
    checks++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id: got %0b want 0", rsp_id); else passes++;
    checks++; if (rsp_tag !== 4'h0) $display("FAIL reset_rsp_tag: got %h want 0", rsp_tag); else passes++;
    checks++; if ({alu_a, alu_b, alu_control} !== 67'h0) $display("FAIL reset_alu_regs: got %h %h %h want 0", alu_a, alu_b, alu_control); else passes++;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready_low: got %b want 00", {req0_ready, req1_ready}); else passes++;
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_single_add;
    exp_t e;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'd0; req0_tag = 4'd2;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL add_accept: got %b want 10", {req0_ready, req1_ready}); else passes++;
    sb.push_back(exp_t'{32'd8, 1'b0, 4'd2});
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) $display("FAIL add_exec_valid: got %0b want 0", rsp_valid); else passes++;
    checks++; if ({alu_a, alu_b, alu_control} !== {32'd5, 32'd3, 3'd0}) $display("FAIL add_alu_regs: got %h %h %h want 5 3 0", alu_a, alu_b, alu_control); else passes++;
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) $display("FAIL add_rsp_valid: got %0b want 1", rsp_valid); else passes++;
    if (sb.size() == 0) begin checks++; $display("FAIL add_sb: scoreboard empty"); end
    else begin
      e = sb.pop_front();
      checks++; if ({rsp_result, rsp_id, rsp_tag} !== e) $display("FAIL add_rsp: got %h want %h", {rsp_result, rsp_id, rsp_tag}, e); else passes++;
    end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) $display("FAIL add_back_idle: got %0b want 0", rsp_valid); else passes++;
    tick();
  endtask

  // Both ports held valid with rsp_ready=1: grants alternate 0,1,0,1,0
  // (all 0 in priority mode), one accept every 2 cycles.
  task automatic test_round_robin_stream;
    exp_t e;
    logic port;
    logic acc;
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_op = 3'd1; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_a = 32'd1;  req1_b = 32'd4; req1_op = 3'd6; req1_tag = 4'd3;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      acc = (k % 2 == 0) && (k <= 8);
`ifdef ALU_ARB_PRIO_EN
      port = 1'b0;
`else
      port = ((k / 2) % 2) == 1;
`endif
      checks++; if ({req0_ready, req1_ready} !== {acc && !port, acc && port})
        $display("FAIL rr_grant k=%0d: got %b want %b", k, {req0_ready, req1_ready}, {acc && !port, acc && port}); else passes++;
      checks++; if (rsp_valid !== ((k % 2 == 0) && (k >= 2) && (k <= 10)))
        $display("FAIL rr_rsp_valid k=%0d: got %0b", k, rsp_valid); else passes++;
      if ((k % 2 == 0) && (k >= 2) && (k <= 10)) begin
        if (sb.size() == 0) begin checks++; $display("FAIL rr_sb k=%0d: scoreboard empty", k); end
        else begin
          e = sb.pop_front();
          checks++; if ({rsp_result, rsp_id, rsp_tag} !== e) $display("FAIL rr_rsp k=%0d: got %h want %h", k, {rsp_result, rsp_id, rsp_tag}, e); else passes++;
        end
      end
      if (acc) sb.push_back(port ? exp_t'{32'd16, 1'b1, 4'd3} : exp_t'{32'd7, 1'b0, 4'd1});
      tick();
      if (k == 8) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    req0_valid = 1'b1; req0_a = 32'h0000_F0F0; req0_b = 32'h0000_0FF0; req0_op = 3'd2; req0_tag = 4'd5;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL bp_accept: got %b want 10", {req0_ready, req1_ready}); else passes++;
    sb.push_back(exp_t'{32'h0000_FF00, 1'b0, 4'd5});
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 3'd3; req1_tag = 4'd6;
    @(negedge clk);
    checks++; if ({rsp_valid, req1_ready} !== 2'b00) $display("FAIL bp_exec: got %b want 00", {rsp_valid, req1_ready}); else passes++;
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_result, req0_ready, req1_ready} !== {1'b1, 32'h0000_FF00, 2'b00})
        $display("FAIL bp_hold c=%0d: got v=%0b r=%h rdy=%b want v=1 r=0000ff00 rdy=00", c, rsp_valid, rsp_result, {req0_ready, req1_ready}); else passes++;
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL bp_release_grant: got %b want 01", {req0_ready, req1_ready}); else passes++;
    if (sb.size() == 0) begin checks++; $display("FAIL bp_sb: scoreboard empty"); end
    else begin
      e = sb.pop_front();
      checks++; if ({rsp_valid, rsp_result, rsp_id, rsp_tag} !== {1'b1, e}) $display("FAIL bp_rsp: got %0b %h want 1 %h", rsp_valid, {rsp_result, rsp_id, rsp_tag}, e); else passes++;
    end
    sb.push_back(exp_t'{32'd3, 1'b1, 4'd6});
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_exec2_valid: got %0b want 0", rsp_valid); else passes++;
    tick();
    @(negedge clk);
    if (sb.size() == 0) begin checks++; $display("FAIL bp_sb2: scoreboard empty"); end
    else begin
      e = sb.pop_front();
      checks++; if ({rsp_valid, rsp_result, rsp_id, rsp_tag} !== {1'b1, e}) $display("FAIL bp_rsp2: got %0b %h want 1 %h", rsp_valid, {rsp_result, rsp_id, rsp_tag}, e); else passes++;
    end
    tick();
  endtask

  task automatic test_reset_in_exec;
    exp_t e;
    req0_valid = 1'b1; req0_a = 32'hFF; req0_b = 32'h0F; req0_op = 3'd4; req0_tag = 4'd7;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) $display("FAIL rx_accept: got %0b want 1", req0_ready); else passes++;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_result, rsp_id, rsp_tag, alu_a, alu_b, alu_control} !== 105'h0)
        $display("FAIL rx_dropped c=%0d: got v=%0b r=%h id=%0b tag=%h a=%h b=%h op=%h want all 0", c, rsp_valid, rsp_result, rsp_id, rsp_tag, alu_a, alu_b, alu_control); else passes++;
      tick();
    end
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = 3'd0; req0_tag = 4'd8;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_op = 3'd1; req1_tag = 4'd9;
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rx_tie_after_reset: got %b want 10", {req0_ready, req1_ready}); else passes++;
    sb.push_back(exp_t'{32'd4, 1'b0, 4'd8});
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    @(negedge clk);
    if (sb.size() == 0) begin checks++; $display("FAIL rx_sb: scoreboard empty"); end
    else begin
      e = sb.pop_front();
      checks++; if ({rsp_valid, rsp_result, rsp_id, rsp_tag} !== {1'b1, e}) $display("FAIL rx_rsp: got %0b %h want 1 %h", rsp_valid, {rsp_result, rsp_id, rsp_tag}, e); else passes++;
    end
    tick();
  endtask

`ifdef ALU_ARB_PRIO_EN
  task automatic test_priority;
    exp_t e;
    logic acc0, acc1;
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'd0; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd3; req1_op = 3'd2; req1_tag = 4'd2;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      acc0 = (k % 2 == 0) && (k <= 6);
      acc1 = (k == 8);
      checks++; if ({req0_ready, req1_ready} !== {acc0, acc1}) $display("FAIL prio_grant k=%0d: got %b want %b", k, {req0_ready, req1_ready}, {acc0, acc1}); else passes++;
      if ((k % 2 == 0) && (k >= 2) && (k <= 10)) begin
        if (sb.size() == 0) begin checks++; $display("FAIL prio_sb k=%0d: scoreboard empty", k); end
        else begin
          e = sb.pop_front();
          checks++; if ({rsp_valid, rsp_result, rsp_id, rsp_tag} !== {1'b1, e}) $display("FAIL prio_rsp k=%0d: got %0b %h want 1 %h", k, rsp_valid, {rsp_result, rsp_id, rsp_tag}, e); else passes++;
        end
      end
      if (acc0) sb.push_back(exp_t'{32'd2, 1'b0, 4'd1});
      if (acc1) sb.push_back(exp_t'{32'd6, 1'b1, 4'd2});
      tick();
      if (k == 6) req0_valid = 1'b0;
      if (k == 8) req1_valid = 1'b0;
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_add();
    test_round_robin_stream();
    test_backpressure();
    test_reset_in_exec();
`ifdef ALU_ARB_PRIO_EN
    test_priority();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
